alu_seq: RTL

Multi-cycle sequencer that owns the single shared 32-bit ALU instance and turns it into a request/response execution unit. Arithmetic and logic ops execute in one pass. Shift/rotate ops are variable-distance: the sequencer iterates the ALU's 1-bit shift/rotate b[4:0] times, feeding each result back as the next operand. It sits between the issue logic and the ALU and drives all ALU inputs.

---
 rtl/alu_seq.sv | 72 +++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: request/response sequencer around a shared 32-bit ALU, iterating 1-bit shifts
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_func,
  input  logic [31:0] alu_out
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, SHIFT = 2'd2;
  logic [1:0]  state;
  logic [31:0] acc, breg;
  logic [3:0]  opreg;
  logic [4:0]  cnt;
  logic        op_shift, reg_shift, reg_ill;
  assign op_shift  = op[3:2] == 2'b01;
  assign reg_shift = opreg[3:2] == 2'b01;
  assign reg_ill   = opreg[3:1] == 3'b001 || opreg[3:1] == 3'b111;
  assign busy      = state != IDLE;
  assign alu_a     = acc;
  assign alu_b     = breg;
  assign alu_func  = opreg;
  // accept a request, run one pass or feed the ALU output back once per remaining shift step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      breg   <= '0;
      opreg  <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc   <= a;
          breg  <= b;
          opreg <= op;
          cnt   <= b[4:0];
          state <= op_shift && b[4:0] != 5'd0 ? SHIFT : RUN;
        end
        RUN: begin
          result <= reg_shift ? acc : reg_ill ? '0 : alu_out;
          err    <= reg_ill;
          done   <= 1'b1;
          state  <= IDLE;
        end
        SHIFT: begin
          acc <= alu_out;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= alu_out;
            err    <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
